// File: rtl/microgreen_frame_features.sv
// rtl/microgreen_frame_features.sv - per-frame colour and canopy-height features from OV7670 RGB565
//
// Purpose: oversamples the OV7670 pixel bus on clk, decodes RGB565 pixels,
//    accumulates strided colour sums and the first "green" line of each frame,
//    and publishes the averages once per valid frame.
// Ports:
//    clk, rst_n        system clock, synchronous active-low reset
//    ena               0 freezes every register (no sampling, no pulses)
//    cam_data[7:0]     OV7670 D bus
//    cam_pclk          OV7670 PCLK (asynchronous, <= clk/4)
//    cam_href          high during an active line
//    cam_vsync         rising edge marks a frame boundary
//    avg_red/avg_green/avg_brightness[7:0]  means over the last valid frame
//    height_pixels[7:0] V_ACTIVE - first green line, 0 when no line was green
//    frame_ready       1-cycle pulse: new statistics on the outputs
//    frame_short       1-cycle pulse: frame ended with too few samples
module microgreen_frame_features #(
   parameter int H_ACTIVE      = 160,
   parameter int V_ACTIVE      = 120,
   parameter int PIX_STRIDE    = 16,
   parameter int SAMPLE_LOG2   = 10,
   parameter int GREEN_MARGIN  = 16,
   parameter int ROW_MIN_GREEN = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] cam_data,
   input  logic       cam_pclk,
   input  logic       cam_href,
   input  logic       cam_vsync,
   output logic [7:0] avg_red,
   output logic [7:0] avg_green,
   output logic [7:0] avg_brightness,
   output logic [7:0] height_pixels,
   output logic       frame_ready,
   output logic       frame_short
);

   localparam int SUM_W = 8 + SAMPLE_LOG2;
   localparam int CNT_W = SAMPLE_LOG2 + 1;
   localparam int STR_W = (PIX_STRIDE > 1) ? $clog2(PIX_STRIDE) : 1;
   localparam logic [CNT_W-1:0] SAMPLE_TARGET = {1'b1, {SAMPLE_LOG2{1'b0}}};
   localparam logic [7:0] H_LIM = 8'(H_ACTIVE);
   localparam logic [7:0] V_LIM = 8'(V_ACTIVE);

   typedef enum logic [1:0] {ST_SYNC, ST_ACTIVE, ST_EVAL} state_t;

   // bit 0/1 are the synchronizer stages, bit 2 is the previous synchronized value
   logic [2:0]       pclk_sync_q, pclk_sync_d, href_sync_q, href_sync_d, vsync_sync_q, vsync_sync_d;
   logic [7:0]       data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   state_t           state_q, state_d;
   logic             phase_q, phase_d, found_q, found_d;
   logic [7:0]       byte0_q, byte0_d, col_q, col_d, line_q, line_d;
   logic [7:0]       row_green_q, row_green_d, first_line_q, first_line_d;
   logic [STR_W-1:0] stride_q, stride_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [SUM_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_y_q, sum_y_d;
   logic [7:0]       avg_red_q, avg_red_d, avg_green_q, avg_green_d;
   logic [7:0]       avg_bright_q, avg_bright_d, height_q, height_d;
   logic             frame_ready_q, frame_ready_d, frame_short_q, frame_short_d;

   logic       pclk_rise, href_rise, href_fall, vsync_rise, in_frame;
   logic       href_rise_ok, href_fall_ok, pix_evt;
   logic [4:0] r5, b5;
   logic [5:0] g6;
   logic [7:0] r8, g8, b8;
   logic [9:0] luma_sum;
   logic       is_green;

   assign pclk_rise  = pclk_sync_q[1] & ~pclk_sync_q[2];
   assign href_rise  = href_sync_q[1] & ~href_sync_q[2];
   assign href_fall  = ~href_sync_q[1] & href_sync_q[2];
   assign vsync_rise = vsync_sync_q[1] & ~vsync_sync_q[2];
   // vsync-high blanking masks all line and pixel activity
   assign in_frame     = (state_q == ST_ACTIVE) && !vsync_sync_q[1];
   assign href_rise_ok = href_rise & in_frame;
   assign href_fall_ok = href_fall & in_frame;
   assign pix_evt      = pclk_rise & href_sync_q[1] & in_frame;

   // pixel completes on byte1, which is the current delayed data byte
   assign r5 = byte0_q[7:3];
   assign g6 = {byte0_q[2:0], data_s2_q[7:5]};
   assign b5 = data_s2_q[4:0];
   assign r8 = {r5, r5[4:2]};
   assign g8 = {g6, g6[5:4]};
   assign b8 = {b5, b5[4:2]};
   assign luma_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
   assign is_green = ({2'b00, g8} > ({2'b00, r8} + 10'(GREEN_MARGIN))) &&
                     ({2'b00, g8} > ({2'b00, b8} + 10'(GREEN_MARGIN)));

   always_comb begin
      pclk_sync_d   = {pclk_sync_q[1:0], cam_pclk};
      href_sync_d   = {href_sync_q[1:0], cam_href};
      vsync_sync_d  = {vsync_sync_q[1:0], cam_vsync};
      data_s1_d     = cam_data;
      data_s2_d     = data_s1_q;
      state_d       = state_q;
      // an href rise restarts the line even if a byte lands in the same cycle
      phase_d       = href_rise_ok ? 1'b0 : phase_q;
      col_d         = href_rise_ok ? 8'd0 : col_q;
      row_green_d   = href_rise_ok ? 8'd0 : row_green_q;
      byte0_d       = byte0_q;
      line_d        = line_q;
      found_d       = found_q;
      first_line_d  = first_line_q;
      stride_d      = stride_q;
      sample_cnt_d  = sample_cnt_q;
      sum_r_d       = sum_r_q;
      sum_g_d       = sum_g_q;
      sum_y_d       = sum_y_q;
      avg_red_d     = avg_red_q;
      avg_green_d   = avg_green_q;
      avg_bright_d  = avg_bright_q;
      height_d      = height_q;
      frame_ready_d = 1'b0;
      frame_short_d = 1'b0;

      if (href_fall_ok && (line_q < V_LIM)) begin
         if (!found_q && (row_green_q >= 8'(ROW_MIN_GREEN))) begin
            found_d      = 1'b1;
            first_line_d = line_q;
         end
         line_d = line_q + 8'd1;
      end

      if (pix_evt) begin
         if (!phase_d) begin
            byte0_d = data_s2_q;
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if ((col_d < H_LIM) && (line_q < V_LIM)) begin
               if (is_green && (row_green_d != 8'hFF)) row_green_d = row_green_d + 8'd1;
               if ((stride_q == '0) && (sample_cnt_q < SAMPLE_TARGET)) begin
                  sample_cnt_d = sample_cnt_q + CNT_W'(1);
                  sum_r_d      = sum_r_q + SUM_W'(r8);
                  sum_g_d      = sum_g_q + SUM_W'(g8);
                  sum_y_d      = sum_y_q + SUM_W'(luma_sum >> 2);
               end
               stride_d = (stride_q == STR_W'(PIX_STRIDE - 1)) ? '0 : stride_q + STR_W'(1);
            end
            if (col_d < H_LIM) col_d = col_d + 8'd1;
         end
      end

      case (state_q)
         ST_SYNC:   if (vsync_rise) state_d = ST_ACTIVE;
         ST_ACTIVE: if (vsync_rise) state_d = ST_EVAL;
         ST_EVAL: begin
            state_d = ST_ACTIVE;
            if (sample_cnt_q == SAMPLE_TARGET) begin
               avg_red_d     = sum_r_q[SUM_W-1:SAMPLE_LOG2];
               avg_green_d   = sum_g_q[SUM_W-1:SAMPLE_LOG2];
               avg_bright_d  = sum_y_q[SUM_W-1:SAMPLE_LOG2];
               height_d      = found_q ? (V_LIM - first_line_q) : 8'd0;
               frame_ready_d = ena;
            end else begin
               frame_short_d = ena;
            end
         end
         default: state_d = ST_SYNC;
      endcase

      if ((state_q == ST_EVAL) || ((state_q == ST_SYNC) && vsync_rise)) begin
         phase_d      = 1'b0;
         col_d        = 8'd0;
         line_d       = 8'd0;
         row_green_d  = 8'd0;
         found_d      = 1'b0;
         first_line_d = 8'd0;
         stride_d     = '0;
         sample_cnt_d = '0;
         sum_r_d      = '0;
         sum_g_d      = '0;
         sum_y_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pclk_sync_q   <= '0;
         href_sync_q   <= '0;
         vsync_sync_q  <= '0;
         data_s1_q     <= '0;
         data_s2_q     <= '0;
         state_q       <= ST_SYNC;
         phase_q       <= 1'b0;
         byte0_q       <= '0;
         col_q         <= '0;
         line_q        <= '0;
         row_green_q   <= '0;
         found_q       <= 1'b0;
         first_line_q  <= '0;
         stride_q      <= '0;
         sample_cnt_q  <= '0;
         sum_r_q       <= '0;
         sum_g_q       <= '0;
         sum_y_q       <= '0;
         avg_red_q     <= '0;
         avg_green_q   <= '0;
         avg_bright_q  <= '0;
         height_q      <= '0;
         frame_ready_q <= 1'b0;
         frame_short_q <= 1'b0;
      end else begin
         // pulses always drop back to 0 so a pulse can never stretch across ena=0
         frame_ready_q <= frame_ready_d;
         frame_short_q <= frame_short_d;
         if (ena) begin
            pclk_sync_q  <= pclk_sync_d;
            href_sync_q  <= href_sync_d;
            vsync_sync_q <= vsync_sync_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            byte0_q      <= byte0_d;
            col_q        <= col_d;
            line_q       <= line_d;
            row_green_q  <= row_green_d;
            found_q      <= found_d;
            first_line_q <= first_line_d;
            stride_q     <= stride_d;
            sample_cnt_q <= sample_cnt_d;
            sum_r_q      <= sum_r_d;
            sum_g_q      <= sum_g_d;
            sum_y_q      <= sum_y_d;
            avg_red_q    <= avg_red_d;
            avg_green_q  <= avg_green_d;
            avg_bright_q <= avg_bright_d;
            height_q     <= height_d;
         end
      end
   end

   assign avg_red        = avg_red_q;
   assign avg_green      = avg_green_q;
   assign avg_brightness = avg_bright_q;
   assign height_pixels  = height_q;
   assign frame_ready    = frame_ready_q;
   assign frame_short    = frame_short_q;

endmodule

// File: tb/tb_microgreen_frame_features.sv
// tb/tb_microgreen_frame_features.sv - randomized frame bench for microgreen_frame_features
module tb_microgreen_frame_features;

   localparam int H_ACT   = 16;
   localparam int V_ACT   = 12;
   localparam int STRIDE  = 2;
   localparam int LOG2    = 6;
   localparam int MARGIN  = 16;
   localparam int ROW_MIN = 4;
   localparam int LIMIT   = 1 << LOG2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] cam_data = 8'd0;
   logic       cam_pclk = 1'b0;
   logic       cam_href = 1'b0;
   logic       cam_vsync = 1'b0;
   logic [7:0] avg_red, avg_green, avg_brightness, height_pixels;
   logic       frame_ready, frame_short;

   microgreen_frame_features #(
      .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .PIX_STRIDE(STRIDE),
      .SAMPLE_LOG2(LOG2), .GREEN_MARGIN(MARGIN), .ROW_MIN_GREEN(ROW_MIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cam_data(cam_data), .cam_pclk(cam_pclk),
      .cam_href(cam_href), .cam_vsync(cam_vsync), .avg_red(avg_red), .avg_green(avg_green),
      .avg_brightness(avg_brightness), .height_pixels(height_pixels),
      .frame_ready(frame_ready), .frame_short(frame_short)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;
   logic [15:0] pix [0:15][0:19];
   int n_lines, n_cols;
   bit synced = 1'b0;
   int exp_r = 0, exp_g = 0, exp_y = 0, exp_h = 0;
   int exp_ready_tot = 0, exp_short_tot = 0;
   int tot_ready = 0, tot_short = 0, tot_both = 0;

   always @(negedge clk) begin
      if (frame_ready) tot_ready++;
      if (frame_short) tot_short++;
      if (frame_ready && frame_short) tot_both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_red"},    {24'd0, avg_red},        exp_r);
      check({tag, "_green"},  {24'd0, avg_green},      exp_g);
      check({tag, "_bright"}, {24'd0, avg_brightness}, exp_y);
      check({tag, "_height"}, {24'd0, height_pixels},  exp_h);
   endtask

   function automatic int widen5(input logic [4:0] v);
      return (int'(v) << 3) | (int'(v) >> 2);
   endfunction

   function automatic int widen6(input logic [5:0] v);
      return (int'(v) << 2) | (int'(v) >> 4);
   endfunction

   // Reference: walk active pixels in raster order, sample every STRIDE-th
   // until LIMIT samples, and find the first line with enough green pixels.
   task automatic model(output bit valid, output int r, output int g, output int y, output int h);
      int a, cnt, sr, sg, sy, first, greens, pr, pg, pb;
      a = 0; cnt = 0; sr = 0; sg = 0; sy = 0; first = -1;
      for (int row = 0; row < n_lines && row < V_ACT; row++) begin
         greens = 0;
         for (int col = 0; col < n_cols && col < H_ACT; col++) begin
            pr = widen5(pix[row][col][15:11]);
            pg = widen6(pix[row][col][10:5]);
            pb = widen5(pix[row][col][4:0]);
            if (pg > pr + MARGIN && pg > pb + MARGIN) greens++;
            if (a % STRIDE == 0 && cnt < LIMIT) begin
               cnt++;
               sr += pr;
               sg += pg;
               sy += (pr + 2 * pg + pb) / 4;
            end
            a++;
         end
         if (greens >= ROW_MIN && first < 0) first = row;
      end
      valid = (cnt == LIMIT);
      r = sr / LIMIT;
      g = sg / LIMIT;
      y = sy / LIMIT;
      h = (first < 0) ? 0 : V_ACT - first;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_pclk = 1'b0;
      cam_data = b;
      tick(2);
      cam_pclk = 1'b1;
      tick(2);
   endtask

   task automatic send_line(input int row, input bit fake);
      logic [15:0] p;
      cam_href = 1'b1;
      for (int col = 0; col < (fake ? 3 : n_cols); col++) begin
         p = fake ? 16'h07E0 : pix[row][col];
         send_byte(p[15:8]);
         send_byte(p[7:0]);
      end
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      tick(6);
   endtask

   task automatic send_vsync(input int want_ready, input int want_short, input string tag);
      int nr, ns, lat;
      nr = 0; ns = 0; lat = 0;
      cam_vsync = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick(1);
         if (frame_ready) begin nr++; if (lat == 0) lat = i; end
         if (frame_short) begin ns++; if (lat == 0) lat = i; end
      end
      // line activity inside vsync-high blanking must be ignored
      send_line(0, 1'b1);
      cam_vsync = 1'b0;
      tick(10);
      check({tag, "_ready_pulses"}, nr, want_ready);
      check({tag, "_short_pulses"}, ns, want_short);
      if (want_ready + want_short > 0) check({tag, "_latency"}, lat, 4);
   endtask

   task automatic run_frame(input string tag, input int rst_at, input bit frozen);
      bit valid;
      int r, g, y, h, er, es;
      er = 0; es = 0;
      for (int row = 0; row < n_lines; row++) begin
         if (row == rst_at) begin
            rst_n = 1'b0;
            tick(2);
            rst_n = 1'b1;
            synced = 1'b0;
            exp_r = 0; exp_g = 0; exp_y = 0; exp_h = 0;
            check_outputs({tag, "_after_reset"});
         end
         send_line(row, 1'b0);
      end
      if (!frozen) begin
         if (!synced) begin
            synced = 1'b1;
         end else begin
            model(valid, r, g, y, h);
            if (valid) begin
               er = 1;
               exp_r = r; exp_g = g; exp_y = y; exp_h = h;
            end else begin
               es = 1;
            end
         end
      end
      exp_ready_tot += er;
      exp_short_tot += es;
      send_vsync(er, es, tag);
      check_outputs(tag);
   endtask

   task automatic fill_split(input int nl, input int nc, input int split,
                             input logic [15:0] top, input logic [15:0] bottom);
      n_lines = nl;
      n_cols  = nc;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 20; c++)
            pix[r][c] = (r < split) ? top : bottom;
   endtask

   task automatic fill_random();
      int line_opts[5] = '{7, 8, 9, 12, 13};
      int col_opts[3] = '{15, 16, 17};
      int start;
      n_lines = line_opts[$urandom_range(0, 4)];
      n_cols  = col_opts[$urandom_range(0, 2)];
      start   = $urandom_range(0, V_ACT);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 20; c++)
            if (r >= start && $urandom_range(0, 3) != 0)
               pix[r][c] = {5'($urandom_range(0, 8)), 6'($urandom_range(40, 63)), 5'($urandom_range(0, 8))};
            else
               pix[r][c] = 16'($urandom);
   endtask

   initial begin
      tick(3);
      check_outputs("reset");
      check("reset_ready", {31'd0, frame_ready}, 0);
      check("reset_short", {31'd0, frame_short}, 0);
      rst_n = 1'b1;
      tick(2);

      fill_split(3, 16, 0, 16'h0000, 16'h07E0);
      run_frame("sync", -1, 1'b0);

      fill_split(12, 16, 0, 16'h0000, 16'h07E0);
      run_frame("all_green", -1, 1'b0);
      check("all_green_const_g", {24'd0, avg_green}, 255);
      check("all_green_const_y", {24'd0, avg_brightness}, 127);
      check("all_green_const_h", {24'd0, height_pixels}, 12);

      fill_split(12, 16, 0, 16'h0000, 16'hF800);
      run_frame("all_red", -1, 1'b0);
      check("all_red_const_r", {24'd0, avg_red}, 255);
      check("all_red_const_y", {24'd0, avg_brightness}, 63);
      check("all_red_const_h", {24'd0, height_pixels}, 0);

      fill_split(12, 16, 6, 16'h0000, 16'h07E0);
      run_frame("split", -1, 1'b0);
      check("split_const_h", {24'd0, height_pixels}, 6);
      check("split_const_g", {24'd0, avg_green}, 63);

      fill_split(5, 16, 0, 16'h0000, 16'h07E0);
      run_frame("short", -1, 1'b0);
      check("short_const_h", {24'd0, height_pixels}, 6);

      fill_split(8, 16, 4, 16'hF800, 16'h07E0);
      run_frame("exact_limit", -1, 1'b0);
      fill_split(8, 15, 0, 16'h0000, 16'h07E0);
      run_frame("one_short", -1, 1'b0);
      fill_split(13, 18, 2, 16'h001F, 16'h07E0);
      run_frame("oversize", -1, 1'b0);

      fill_split(12, 16, 0, 16'h0000, 16'h07E0);
      run_frame("mid_reset", 4, 1'b0);
      fill_split(12, 16, 3, 16'hFFFF, 16'h07E0);
      run_frame("post_reset", -1, 1'b0);

      ena = 1'b0;
      fill_split(12, 16, 0, 16'h0000, 16'hF800);
      run_frame("frozen", -1, 1'b1);
      ena = 1'b1;
      tick(4);
      fill_split(12, 16, 9, 16'h0000, 16'h07E0);
      run_frame("resume", -1, 1'b0);

      repeat (5) begin
         fill_random();
         run_frame("random", -1, 1'b0);
      end

      check("total_ready", tot_ready, exp_ready_tot);
      check("total_short", tot_short, exp_short_tot);
      check("ready_and_short", tot_both, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
